// File: rtl/rx_elastic_wr_ctrl_if.sv
// Upstream character channel into the RX elastic FIFO write controller.
//   rx_data  : decoded character {k_flag, byte[7:0]}
//   rx_valid : rx_data valid this cycle
//   rx_ready : character accepted this cycle (low only while a duplicate SKIP is inserted)
// master = upstream decoder side, slave = write controller side.
interface rx_elastic_wr_ctrl_if #(
  parameter int unsigned DW = 9
);
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/rx_elastic_wr_ctrl.sv
// Write-side controller of the PCS RX clock-compensation FIFO (wclk domain).
// Each cycle decides whether the write pointer advances (winc) and what is
// written (wdata); deletes SKIPs near full and inserts a duplicate SKIP near empty.
// Ports:
//   wclk, wrst     : write clock, synchronous active-high reset
//   rx             : upstream rx_data/rx_valid/rx_ready channel (slave modport)
//   wptr           : Gray write pointer from the write-pointer/full block
//   wq2_rptr       : Gray read pointer synchronized into wclk
//   winc, wdata    : registered write strobe and write data
//   fill           : combinational effective fill level
//   ovf_err        : sticky overflow flag, cleared only by wrst
//   ins_cnt/del_cnt: saturating insert/delete counters (only with RX_ELASTIC_STATS_EN)
// Optional feature macro: RX_ELASTIC_STATS_EN
module rx_elastic_wr_ctrl #(
  parameter int unsigned   ADDRSIZE  = 3,
  parameter int unsigned   DW        = 9,
  parameter logic [DW-1:0] SKIP_CODE = DW'(9'h11C),
  parameter int unsigned   HI_WM     = 6,
  parameter int unsigned   LO_WM     = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  rx_elastic_wr_ctrl_if.slave   rx,
  input  logic [ADDRSIZE:0]     wptr,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  output logic                  winc,
  output logic [DW-1:0]         wdata,
  output logic [ADDRSIZE:0]     fill,
`ifdef RX_ELASTIC_STATS_EN
  output logic [15:0]           ins_cnt,
  output logic [15:0]           del_cnt,
`endif
  output logic                  ovf_err
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned FW    = ADDRSIZE + 2;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  typedef enum logic {NORM, INS} state_t;

  state_t        state;
  logic          ready;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_raw;
  logic [FW-1:0] fill_eff;
  logic          full_eff;
  logic          hi_c;
  logic          lo_c;
  logic          skip_c;
  logic          xfer_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Fill level, widened by one bit so the pending registered write cannot wrap it
  always_comb begin
    wbin     = gray2bin(wptr);
    rbin     = gray2bin(wq2_rptr);
    fill_raw = wbin - rbin;
    fill_eff = FW'(fill_raw) + FW'(winc);
    full_eff = (fill_eff >= FW'(DEPTH));
    hi_c     = (fill_eff >= FW'(HI_WM));
    lo_c     = (fill_eff <= FW'(LO_WM));
    skip_c   = (rx.rx_data == SKIP_CODE);
    xfer_c   = rx.rx_valid && ready;
  end

  assign fill        = fill_eff[PW-1:0];
  assign rx.rx_ready = ready;

  // Write/skip-management FSM; precedence full-drop > delete > insert > write
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state   <= NORM;
      ready   <= 1'b1;
      winc    <= 1'b0;
      wdata   <= '0;
      ovf_err <= 1'b0;
`ifdef RX_ELASTIC_STATS_EN
      ins_cnt <= '0;
      del_cnt <= '0;
`endif
    end else begin
      winc <= 1'b0;
      case (state)
        NORM: begin
          if (xfer_c) begin
            if (full_eff) begin
              ovf_err <= 1'b1;
            end else if (skip_c && hi_c) begin
`ifdef RX_ELASTIC_STATS_EN
              if (del_cnt != 16'hFFFF) del_cnt <= del_cnt + 16'd1;
`endif
            end else if (skip_c && lo_c) begin
              winc  <= 1'b1;
              wdata <= rx.rx_data;
              state <= INS;
              ready <= 1'b0;
            end else begin
              winc  <= 1'b1;
              wdata <= rx.rx_data;
            end
          end
        end
        INS: begin
          // Duplicate SKIP; abandoned silently if the FIFO filled meanwhile
          state <= NORM;
          ready <= 1'b1;
          if (!full_eff) begin
            winc  <= 1'b1;
            wdata <= SKIP_CODE;
`ifdef RX_ELASTIC_STATS_EN
            if (ins_cnt != 16'hFFFF) ins_cnt <= ins_cnt + 16'd1;
`endif
          end
        end
        default: begin
          state <= NORM;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_elastic_wr_ctrl.sv
module tb_rx_elastic_wr_ctrl;

  localparam logic [8:0] SKIP = 9'h11C;

  logic       wclk = 1'b0;
  logic       wrst;
  logic [3:0] wptr;
  logic [3:0] wq2_rptr;
  logic       winc;
  logic [8:0] wdata;
  logic [3:0] fill;
  logic       ovf_err;
`ifdef RX_ELASTIC_STATS_EN
  logic [15:0] ins_cnt;
  logic [15:0] del_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rx_elastic_wr_ctrl_if #(.DW(9)) bus ();

  rx_elastic_wr_ctrl dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .rx       (bus),
    .wptr     (wptr),
    .wq2_rptr (wq2_rptr),
    .winc     (winc),
    .wdata    (wdata),
    .fill     (fill),
`ifdef RX_ELASTIC_STATS_EN
    .ins_cnt  (ins_cnt),
    .del_cnt  (del_cnt),
`endif
    .ovf_err  (ovf_err)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input logic [3:0] g);
    int b;
    b = int'(g);
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    return b;
  endfunction

  // Reference model: expected registered outputs, advanced once per edge
  logic        m_winc, m_ins, m_ovf;
  logic [8:0]  m_wdata;
  int          m_ins_cnt, m_del_cnt;

  task automatic model_reset();
    m_winc = 0; m_ins = 0; m_ovf = 0; m_wdata = '0; m_ins_cnt = 0; m_del_cnt = 0;
  endtask

  function automatic int model_fill(input logic [3:0] wg, input logic [3:0] rg);
    return ((g2b(wg) - g2b(rg)) & 15) + int'(m_winc);
  endfunction

  task automatic model_edge(input logic rst, input logic v, input logic [8:0] d,
                            input logic [3:0] wg, input logic [3:0] rg);
    int  fe;
    bit  full, skip;
    fe   = model_fill(wg, rg);
    full = (fe >= 8);
    skip = (d == SKIP);
    if (rst) begin
      model_reset();
    end else if (m_ins) begin
      m_ins = 0;
      if (!full) begin
        m_winc = 1; m_wdata = SKIP;
        if (m_ins_cnt < 16'hFFFF) m_ins_cnt++;
      end else begin
        m_winc = 0;
      end
    end else begin
      m_winc = 0;
      if (v) begin
        if (full) m_ovf = 1;
        else if (skip && fe >= 6) begin
          if (m_del_cnt < 16'hFFFF) m_del_cnt++;
        end else if (skip && fe <= 2) begin
          m_winc = 1; m_wdata = d; m_ins = 1;
        end else begin
          m_winc = 1; m_wdata = d;
        end
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [8:0] d;
    logic [3:0] wb;
    logic [3:0] rb;
    logic       cf;
    logic [3:0] ef;
    logic       ewinc;
    logic [8:0] ewdata;
    logic       erdy;
    logic       eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic v, input logic [8:0] d,
                     input logic [3:0] wb, input logic [3:0] rb,
                     input logic cf, input logic [3:0] ef,
                     input logic ewinc, input logic [8:0] ewdata,
                     input logic erdy, input logic eovf);
    vec_t t;
    t = '{rst, v, d, wb, rb, cf, ef, ewinc, ewdata, erdy, eovf};
    tbl.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic v, input logic [8:0] d,
                       input logic [3:0] wg, input logic [3:0] rg);
    wrst = rst; bus.rx_valid = v; bus.rx_data = d; wptr = wg; wq2_rptr = rg;
  endtask

  initial begin
    drive(1'b1, 1'b0, 9'h0, 4'h0, 4'h0);

    //   rst v  data    wb  rb  cf fill  winc wdata   rdy ovf
    add(1, 0, 9'h000,  0,  0, 0, 0,    0, 9'h000,  1, 0); // reset
    add(1, 0, 9'h000,  0,  0, 1, 0,    0, 9'h000,  1, 0);
    add(0, 1, 9'h0AA,  4,  0, 1, 4,    1, 9'h0AA,  1, 0); // normal stream
    add(0, 1, 9'h055,  4,  0, 1, 5,    1, 9'h055,  1, 0);
    add(0, 0, 9'h000,  4,  0, 1, 5,    0, 9'h055,  1, 0);
    add(0, 1, SKIP,    6,  0, 1, 6,    0, 9'h055,  1, 0); // delete at HI_WM
    add(0, 1, 9'h012,  6,  0, 1, 6,    1, 9'h012,  1, 0);
    add(0, 0, 9'h000,  6,  0, 1, 7,    0, 9'h012,  1, 0);
    add(0, 1, SKIP,    5,  5, 1, 0,    1, SKIP,    0, 0); // insert
    add(0, 1, SKIP,    5,  5, 1, 1,    1, SKIP,    1, 0); // duplicate
    add(0, 0, 9'h000,  5,  5, 1, 1,    0, SKIP,    1, 0);
    add(0, 1, 9'h033,  2, 10, 1, 8,    0, SKIP,    1, 1); // wrapped full -> drop
    add(0, 0, 9'h000,  2,  2, 1, 0,    0, SKIP,    1, 1); // drained, sticky
    add(0, 1, 9'h077,  2,  2, 1, 0,    1, 9'h077,  1, 1);
    add(1, 0, 9'h000,  0,  0, 1, 1,    0, 9'h000,  1, 0);
    add(0, 1, SKIP,    1,  0, 1, 1,    1, SKIP,    0, 0); // insert
    add(0, 1, SKIP,    7,  0, 1, 8,    0, SKIP,    1, 0); // abort, no ovf
    add(0, 0, 9'h000,  7,  0, 1, 7,    0, SKIP,    1, 0);
    add(0, 1, SKIP,    5,  0, 1, 5,    1, SKIP,    1, 0); // HI_WM-1 -> write
    add(0, 1, SKIP,    2,  0, 1, 3,    1, SKIP,    1, 0); // LO_WM+1 -> write
    add(0, 1, SKIP,    1,  0, 1, 2,    1, SKIP,    0, 0); // LO_WM incl. winc
    add(0, 0, 9'h000,  1,  0, 1, 2,    1, SKIP,    1, 0);
    add(0, 1, SKIP,   14,  8, 1, 7,    0, SKIP,    1, 0); // delete
    add(0, 0, 9'h000, 14,  8, 1, 6,    0, SKIP,    1, 0);

    @(posedge wclk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, b2g(tbl[i].wb), b2g(tbl[i].rb));
      #1;
      if (tbl[i].cf) chk($sformatf("vec%0d fill", i), 32'(fill), 32'(tbl[i].ef));
      @(posedge wclk); #1;
      chk($sformatf("vec%0d winc", i), 32'(winc), 32'(tbl[i].ewinc));
      chk($sformatf("vec%0d wdata", i), 32'(wdata), 32'(tbl[i].ewdata));
      chk($sformatf("vec%0d rx_ready", i), 32'(bus.rx_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d ovf_err", i), 32'(ovf_err), 32'(tbl[i].eovf));
    end

    // Reset while a duplicate SKIP is pending abandons it
    drive(1, 0, 9'h0, 4'h0, 4'h0);
    @(posedge wclk); #1;
    drive(0, 1, SKIP, 4'h0, 4'h0);
    @(posedge wclk); #1;
    chk("rstins first winc", 32'(winc), 32'd1);
    chk("rstins first ready", 32'(bus.rx_ready), 32'd0);
    drive(1, 1, SKIP, 4'h0, 4'h0);
    @(posedge wclk); #1;
    chk("rstins winc", 32'(winc), 32'd0);
    chk("rstins ready", 32'(bus.rx_ready), 32'd1);
    drive(0, 1, 9'h0AA, 4'h0, 4'h0);
    @(posedge wclk); #1;
    chk("rstins next winc", 32'(winc), 32'd1);
    chk("rstins next wdata", 32'(wdata), 32'h0AA);
    chk("rstins next ready", 32'(bus.rx_ready), 32'd1);

    // Randomized run against the reference model
    drive(1, 0, 9'h0, 4'h0, 4'h0);
    model_reset();
    @(posedge wclk); #1;
    for (int n = 0; n < 3000; n++) begin
      logic       rst, v;
      logic [8:0] d;
      logic [3:0] rb, wb;
      rst = ($urandom_range(199) == 0);
      if (m_ins) begin
        v = bus.rx_valid;
        d = bus.rx_data;
      end else begin
        v = ($urandom_range(3) != 0);
        d = ($urandom_range(2) == 0) ? SKIP : 9'($urandom);
      end
      rb = 4'($urandom);
      wb = rb + 4'($urandom_range(8));
      drive(rst, v, d, b2g(wb), b2g(rb));
      #1;
      chk("rnd fill", 32'(fill), 32'(model_fill(b2g(wb), b2g(rb))));
      model_edge(rst, v, d, b2g(wb), b2g(rb));
      @(posedge wclk); #1;
      chk("rnd winc", 32'(winc), 32'(m_winc));
      if (m_winc) chk("rnd wdata", 32'(wdata), 32'(m_wdata));
      chk("rnd rx_ready", 32'(bus.rx_ready), 32'(!m_ins));
      chk("rnd ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef RX_ELASTIC_STATS_EN
      chk("rnd ins_cnt", 32'(ins_cnt), 32'(m_ins_cnt));
      chk("rnd del_cnt", 32'(del_cnt), 32'(m_del_cnt));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_elastic_wr_ctrl.md
Name: rx_elastic_wr_ctrl

Overview:
- Write-side controller for the PCS RX clock-compensation (elastic) FIFO, in the wclk domain.
- Decides each cycle whether the write pointer/full block advances (winc) and what is written (wdata).
- Uses the FIFO fill level to delete SKIP characters near full and insert duplicate SKIPs near empty.
- Converts the synchronized read pointer and the local write pointer from Gray to binary to compute fill.

Parameters:
- ADDRSIZE, 3, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- DW, 9, data width ({k_flag, byte[7:0]}).
- SKIP_CODE, 9'h11C, SKIP character value (K28.0).
- HI_WM, 6, delete threshold; fill_eff >= HI_WM enables deletion.
- LO_WM, 2, insert threshold; fill_eff <= LO_WM enables insertion.

Ports:
- wclk, input, 1, write clock.
- wrst, input, 1, synchronous active-high reset.
- rx_data, input, DW, incoming decoded character.
- rx_valid, input, 1, rx_data valid this cycle.
- rx_ready, output, 1, character accepted this cycle; low only during insertion.
- wptr, input, ADDRSIZE+1, Gray write pointer from the write-pointer/full block.
- wq2_rptr, input, ADDRSIZE+1, Gray read pointer synchronized into wclk.
- winc, output, 1, registered write strobe to the write-pointer/full block and the memory.
- wdata, output, DW, registered write data.
- fill, output, ADDRSIZE+1, combinational fill_eff.
- ovf_err, output, 1, sticky overflow flag.

Behaviour:
- Reset (wrst sampled high on a wclk edge): winc=0, wdata=0, ovf_err=0, state=NORM, all counters 0. rx_ready=1 out of reset. Reset mid-insertion abandons the duplicate SKIP.
- Gray-to-binary: b[ADDRSIZE]=g[ADDRSIZE]; b[i]=b[i+1]^g[i].
- fill_raw = wbin - rbin, modulo 2^(ADDRSIZE+1), range 0..2^ADDRSIZE.
- fill_eff = fill_raw + winc. This accounts for the registered write not yet reflected in wptr.
- full_eff = (fill_eff >= 2^ADDRSIZE).
- Latency: an accepted character reaches winc/wdata on the next wclk edge, 1 cycle.
- Handshake: a transfer occurs when rx_valid && rx_ready. Upstream holds rx_data while rx_ready=0.
- State NORM, rx_ready=1. On a transfer:
  - skip && fill_eff >= HI_WM: delete. winc=0, del_cnt++, stay NORM.
  - skip && fill_eff <= LO_WM && !full_eff: write the SKIP (winc=1, wdata=rx_data), go to INS.
  - any character && full_eff: drop. winc=0, ovf_err<=1, stay NORM.
  - otherwise: write it, winc=1.
  - no transfer: winc=0.
- Precedence when conditions overlap: full-drop > delete > insert > normal write.
- State INS, rx_ready=0, input ignored:
  - !full_eff: winc=1, wdata=SKIP_CODE, ins_cnt++, go to NORM.
  - full_eff: winc=0, abort insertion, go to NORM. ovf_err is not set.
- Wrap-around: modulo subtraction gives the correct fill across pointer wrap, including wbin < rbin numerically.
- HI_WM must exceed LO_WM; behaviour is undefined otherwise.
- ovf_err clears only on wrst.

Optional Feature:
- Macro RX_ELASTIC_STATS_EN.
- When defined: adds outputs ins_cnt[15:0] and del_cnt[15:0].
  - Each saturates at 16'hFFFF.
  - Each is reset to 0 by wrst.
  - Each increments exactly on a completed insertion or deletion.
- When undefined: the ports and counters are absent. Datapath behaviour is identical.

Test Plan:
- Reset: hold wrst 2 cycles, wptr=wq2_rptr=0 -> winc=0, wdata=0, fill=0, rx_ready=1, ovf_err=0.
- Normal stream: fill=4, send 9'h0AA, 9'h055 back-to-back -> winc=1 on the following two cycles with wdata 0AA then 055, rx_ready stays 1.
- Deletion: wbin=6, rbin=0, send SKIP -> no winc, rx_ready=1. Send 9'h012 -> written next cycle. del_cnt=1 with stats enabled.
- Insertion: wbin=rbin=5 (Gray 4'b0111), send SKIP -> winc=1 for 2 consecutive cycles with wdata=11C, rx_ready=0 in the second cycle, ins_cnt=1.
- Wrap/full: wbin=4'b0010, rbin=4'b1010 (fill=8), send 9'h033 -> no winc, ovf_err=1 and remains 1 after the FIFO drains.
- Insertion abort: fill_eff reaches 8 during INS -> duplicate SKIP is not written, return to NORM, ovf_err unchanged.
